if_id_queue: RTL

- Parametrised successor to the single-entry IF/ID pipeline register.
- Sits between the fetch and decode stages. It buffers up to DEPTH fetched instruction/PC pairs in a small in-order queue.
- Adds a valid/ready handshake, a per-entry valid bit, flush for branch/jump redirect, and NOP insertion when empty.
- The decode-side stall keeps its existing meaning: while stalled, the output holds.

---
 rtl/if_id_queue.sv | 85 ++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// IF/ID queue: buffers up to DEPTH fetched instruction/PC pairs between fetch
// and decode. Uses a valid/ready push side, a decode stall, flush on redirect,
// and drives a NOP on the output whenever the queue is empty.
module if_id_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    PC_WIDTH   = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_valid,
  input  logic [DATA_WIDTH-1:0]        i_instruccion,
  input  logic [PC_WIDTH-1:0]          i_pc,
  output logic                         o_ready,
  input  logic                         i_if_id_burbuja,
  input  logic                         i_flush,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_instruccion,
  output logic [PC_WIDTH-1:0]          o_pc,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  // No full pass-through: a full queue refuses even if decode pops this cycle.
  assign o_ready = (count < CW'(DEPTH));
  assign o_valid = (count != '0) & ent_vld[rd_ptr];
  assign o_count = count;
  assign push    = i_valid & o_ready & ~i_flush;
  assign pop     = o_valid & ~i_if_id_burbuja & ~i_flush;

  // Head mux: registered entry when valid, otherwise NOP / zero PC.
  always_comb begin
    o_instruccion = NOP_INSTR;
    o_pc          = '0;
    if (o_valid) begin
      o_instruccion = mem[rd_ptr].instr;
      o_pc          = mem[rd_ptr].pc;
    end
  end

  // Pointers, occupancy and per-entry valid bits; flush beats push/pop/stall.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && (rd_ptr == PW'(i)))       ent_vld[i] <= 1'b0;
        if (push && (wr_ptr == PW'(i)))      ent_vld[i] <= 1'b1;
      end
    end
  end

  // Entry payload carries no reset; contents only matter once marked valid.
  always_ff @(posedge i_clock) begin
    if (i_reset && push) mem[wr_ptr] <= '{instr: i_instruccion, pc: i_pc};
  end
endmodule
